// File: rtl/uncached_data_bridge.sv
// uncached_data_bridge: single-beat AXI reads/writes for uncached CPU data accesses
module uncached_data_bridge #(
    parameter logic [3:0] AXI_ID  = 4'd1,
    parameter logic [2:0] RD_SIZE = 3'b010
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic [31:0] addr_i,
    input  logic        ren_i,
    input  logic [3:0]  wen_i,
    input  logic [31:0] wdata_i,
    input  logic        cache_ena_i,
    output logic        read_ok_o,
    output logic        write_ok_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic [1:0]  arlock_o,
    output logic [3:0]  arcache_o,
    output logic [2:0]  arprot_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic [1:0]  awlock_o,
    output logic [3:0]  awcache_o,
    output logic [2:0]  awprot_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] araddr_q, awaddr_q, wdata_q, rdata_q;
    logic [2:0]  awsize_q, wsize;
    logic [1:0]  woff;
    logic [3:0]  wstrb_q;
    logic        awdone_q, wdone_q, discard_q, read_ok_q, write_ok_q;
    logic        rd_acc, wr_acc, r_hit, b_hit, aw_ok, w_ok;
    logic        unused_ok;

    // Response errors and rlast carry no information for single-beat accesses
    assign unused_ok = ^{rresp_i, bresp_i, rlast_i, addr_i[1:0]};

    assign rd_acc = state_q == IDLE && !flush_i && !cache_ena_i && ren_i;
    assign wr_acc = state_q == IDLE && !flush_i && !cache_ena_i && !ren_i && |wen_i;
    assign r_hit  = state_q == RD_DATA && rvalid_i && rid_i == AXI_ID;
    assign b_hit  = state_q == WR_RESP && bvalid_i && bid_i == AXI_ID;
    assign aw_ok  = awdone_q || awready_i;
    assign w_ok   = wdone_q || wready_i;

    // Narrow write size and low address bits derived from the byte strobes
    always_comb begin
        wsize = 3'd2;
        woff  = 2'b00;
        case (wen_i)
            4'b0011: wsize = 3'd1;
            4'b1100: begin wsize = 3'd1; woff = 2'b10; end
            4'b0001: wsize = 3'd0;
            4'b0010: begin wsize = 3'd0; woff = 2'b01; end
            4'b0100: begin wsize = 3'd0; woff = 2'b10; end
            4'b1000: begin wsize = 3'd0; woff = 2'b11; end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rd_acc ? RD_ADDR : wr_acc ? WR_REQ : IDLE;
            RD_ADDR: state_d = arready_i ? RD_DATA : RD_ADDR;
            RD_DATA: state_d = r_hit ? HOLD : RD_DATA;
            WR_REQ:  state_d = (aw_ok && w_ok) ? WR_RESP : WR_REQ;
            WR_RESP: state_d = b_hit ? HOLD : WR_RESP;
            default: state_d = IDLE;
        endcase
    end

    // State, handshake tracking, discard flag and ok pulses
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            awdone_q   <= 1'b0;
            wdone_q    <= 1'b0;
            discard_q  <= 1'b0;
            read_ok_q  <= 1'b0;
            write_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            awdone_q   <= state_q == WR_REQ && state_d == WR_REQ && aw_ok;
            wdone_q    <= state_q == WR_REQ && state_d == WR_REQ && w_ok;
            discard_q  <= state_q != IDLE && state_q != HOLD && (discard_q || flush_i);
            read_ok_q  <= r_hit && !discard_q && !flush_i;
            write_ok_q <= b_hit && !discard_q && !flush_i;
        end
    end

    // Request capture and read data register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            araddr_q <= '0;
            awaddr_q <= '0;
            awsize_q <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (rd_acc) araddr_q <= {addr_i[31:2], 2'b00};
            if (wr_acc) begin
                awaddr_q <= {addr_i[31:2], woff};
                awsize_q <= wsize;
                wstrb_q  <= wen_i;
                wdata_q  <= wdata_i;
            end
            if (r_hit) rdata_q <= rdata_i;
        end
    end

    assign read_ok_o  = read_ok_q;
    assign write_ok_o = write_ok_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = state_q != IDLE;
    assign arvalid_o  = state_q == RD_ADDR;
    assign rready_o   = state_q == RD_DATA;
    assign awvalid_o  = state_q == WR_REQ && !awdone_q;
    assign wvalid_o   = state_q == WR_REQ && !wdone_q;
    assign bready_o   = state_q == WR_RESP;
    assign araddr_o   = araddr_q;
    assign arsize_o   = RD_SIZE;
    assign awaddr_o   = awaddr_q;
    assign awsize_o   = awsize_q;
    assign wdata_o    = wdata_q;
    assign wstrb_o    = wstrb_q;
    assign wlast_o    = 1'b1;
    assign arid_o     = AXI_ID;
    assign awid_o     = AXI_ID;
    assign wid_o      = AXI_ID;
    assign arlen_o    = '0;
    assign awlen_o    = '0;
    assign arburst_o  = 2'b01;
    assign awburst_o  = 2'b01;
    assign arlock_o   = '0;
    assign awlock_o   = '0;
    assign arcache_o  = '0;
    assign awcache_o  = '0;
    assign arprot_o   = '0;
    assign awprot_o   = '0;
endmodule

// File: tb/tb_uncached_data_bridge.sv
// tb_uncached_data_bridge: directed checks of the uncached AXI data bridge
module tb_uncached_data_bridge;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ren = 1'b0, cena = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata_in = '0;
    logic [3:0]  wen = '0, rid = '0, bid = '0;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic        read_ok, write_ok, busy, arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [31:0] rdata, araddr, awaddr, wdata_out;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [3:0]  arid, awid, wid, arlen, awlen, arcache, awcache, wstrb;
    logic [1:0]  arburst, awburst, arlock, awlock;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    uncached_data_bridge dut (
        .clock_i(clk), .reset_i(rst_n), .flush_i(flush), .addr_i(addr), .ren_i(ren),
        .wen_i(wen), .wdata_i(wdata), .cache_ena_i(cena),
        .read_ok_o(read_ok), .write_ok_o(write_ok), .rdata_o(rdata), .busy_o(busy),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
        .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot),
        .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata_in), .rresp_i(2'b00), .rlast_i(1'b1), .rvalid_i(rvalid),
        .rready_o(rready),
        .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
        .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot),
        .awvalid_o(awvalid), .awready_i(awready),
        .wid_o(wid), .wdata_o(wdata_out), .wstrb_o(wstrb), .wlast_o(wlast),
        .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(2'b10), .bvalid_i(bvalid), .bready_o(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_bready", 32'(bready), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_readok", 32'(read_ok), 0);
        chk("const_ids", {arid, awid, wid, 20'd0}, {4'd1, 4'd1, 4'd1, 20'd0});
        rst_n = 1'b1;
        // uncached lw, zero-wait slave
        ren = 1'b1; addr = 32'h1FAF_8004;
        step();
        ren = 1'b0;
        chk("lw_arvalid", 32'(arvalid), 1);
        chk("lw_araddr", araddr, 32'h1FAF_8004);
        chk("lw_arsize", 32'(arsize), 2);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("lw_rready", 32'(rready), 1);
        chk("lw_readok_early", 32'(read_ok), 0);
        rvalid = 1'b1; rid = 4'd1; rdata_in = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        chk("lw_readok", 32'(read_ok), 1);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        step();
        chk("lw_readok_done", 32'(read_ok), 0);
        chk("lw_idle", 32'(busy), 0);
        // sb, strobe 0100
        wen = 4'b0100; addr = 32'h1FAF_F020; wdata = 32'h00AA_0000;
        step();
        chk("sb_awaddr", awaddr, 32'h1FAF_F022);
        chk("sb_awsize", 32'(awsize), 0);
        chk("sb_wstrb", 32'(wstrb), 32'h4);
        chk("sb_wdata", wdata_out, 32'h00AA_0000);
        chk("sb_valids", {30'd0, awvalid, wvalid}, 3);
        chk("sb_wlast", 32'(wlast), 1);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        chk("sb_bready", 32'(bready), 1);
        chk("sb_valids_off", {30'd0, awvalid, wvalid}, 0);
        bvalid = 1'b1; bid = 4'd1;
        step();
        bvalid = 1'b0;
        chk("sb_writeok", 32'(write_ok), 1);
        step();
        wen = 4'b0000;
        chk("sb_writeok_once", 32'(write_ok), 0);
        chk("sb_no_rewrite", 32'(busy), 0);
        step();
        chk("sb_still_idle", 32'(busy), 0);
        // AW/W skew plus a mismatched bid
        wen = 4'b1111; addr = 32'h1000_0003; wdata = 32'h1234_5678;
        step();
        chk("sk_awaddr", awaddr, 32'h1000_0000);
        chk("sk_awsize", 32'(awsize), 2);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("sk_aw_dropped", 32'(awvalid), 0);
        chk("sk_w_held", 32'(wvalid), 1);
        chk("sk_no_bready", 32'(bready), 0);
        step();
        chk("sk_w_held2", 32'(wvalid), 1);
        step();
        chk("sk_w_held3", 32'(wvalid), 1);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("sk_w_dropped", 32'(wvalid), 0);
        chk("sk_bready", 32'(bready), 1);
        bvalid = 1'b1; bid = 4'd2;
        step();
        chk("sk_badbid_stay", 32'(bready), 1);
        chk("sk_badbid_noack", 32'(write_ok), 0);
        bid = 4'd1;
        step();
        bvalid = 1'b0;
        chk("sk_writeok", 32'(write_ok), 1);
        step();
        wen = 4'b0000;
        chk("sk_writeok_once", 32'(write_ok), 0);
        chk("sk_idle", 32'(busy), 0);
        // flush during RD_DATA, R beat delayed
        ren = 1'b1; addr = 32'h0000_0010;
        step();
        ren = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fl_rready", 32'(rready), 1);
            chk("fl_no_ok", 32'(read_ok), 0);
            step();
        end
        rvalid = 1'b1; rid = 4'd1; rdata_in = 32'h0000_0055;
        step();
        rvalid = 1'b0;
        chk("fl_consumed", 32'(rready), 0);
        chk("fl_discarded", 32'(read_ok), 0);
        step();
        chk("fl_idle", 32'(busy), 0);
        chk("fl_no_ok_late", 32'(read_ok), 0);
        // next read after flush, with a stray wrong-rid beat first
        ren = 1'b1; addr = 32'h0000_0022;
        step();
        ren = 1'b0;
        chk("nr_araddr", araddr, 32'h0000_0020);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd3; rdata_in = 32'h1111_1111;
        step();
        chk("nr_badrid_stay", 32'(rready), 1);
        rid = 4'd1; rdata_in = 32'hCAFE_F00D;
        step();
        rvalid = 1'b0;
        chk("nr_readok", 32'(read_ok), 1);
        chk("nr_rdata", rdata, 32'hCAFE_F00D);
        step();
        // cached access is ignored
        ren = 1'b1; cena = 1'b1;
        step();
        step();
        chk("ce_busy", 32'(busy), 0);
        chk("ce_arvalid", 32'(arvalid), 0);
        cena = 1'b0; flush = 1'b1;
        step();
        chk("fi_not_accepted", 32'(busy), 0);
        flush = 1'b0; wen = 4'b1111;
        step();
        ren = 1'b0; wen = 4'b0000;
        chk("pri_arvalid", 32'(arvalid), 1);
        chk("pri_awvalid", 32'(awvalid), 0);
        arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        step();
        chk("pri_done", 32'(busy), 0);
        // async reset during WR_RESP
        wen = 4'b0011; addr = 32'h0000_0040;
        step();
        chk("rw_awsize", 32'(awsize), 1);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        chk("rw_bready", 32'(bready), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_bready_rst", 32'(bready), 0);
        chk("rw_busy_rst", 32'(busy), 0);
        chk("rw_rdata_rst", rdata, 0);
        wen = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        chk("rw_idle_after", 32'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uncached_data_bridge.md
Name: uncached_data_bridge

Overview:
- Sits directly downstream of the CPU-side SRAM interface, on its data port.
- Services data accesses that arrive with data_cache_ena_o=0 (uncached kseg1 / device space): one single-beat AXI read or write per request, with read_ok/write_ok and rdata returned upstream.
- Cached accesses (ena=1) are ignored; the data cache owns them.
- In-flight AXI transactions are never aborted on flush; they are drained silently.

Parameters:
- AXI_ID, 4'd1: constant arid/awid/wid value; the block checks it against rid/bid.
- RD_SIZE, 3'b010: arsize for reads (the read request carries no byte info).

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush; suppresses completion of the current request
- addr_i  in  32  physical address (already translated upstream)
- ren_i  in  1  read request; a single-cycle pulse is sufficient
- wen_i  in  4  byte write strobes; held until write_ok_o
- wdata_i  in  32  write data
- cache_ena_i  in  1  0 = uncached (this block), 1 = ignore
- read_ok_o  out  1  one-cycle pulse; rdata_o valid in the same cycle
- write_ok_o  out  1  one-cycle pulse
- rdata_o  out  32  read data
- busy_o  out  1  state != IDLE
- araddr_o/arsize_o/arvalid_o  out  32/3/1  AR channel; arready_i in 1
- rdata_i/rresp_i/rid_i/rlast_i/rvalid_i  in  32/2/4/1/1  R channel; rready_o out 1
- awaddr_o/awsize_o/awvalid_o  out  32/3/1  AW channel; awready_i in 1
- wdata_o/wstrb_o/wlast_o/wvalid_o  out  32/4/1/1  W channel; wready_i in 1
- bresp_i/bid_i/bvalid_i  in  2/4/1  B channel; bready_o out 1
- arid_o/awid_o/wid_o = AXI_ID; arlen_o/awlen_o = 0; arburst_o/awburst_o = 2'b01; arlock_o/awlock_o = 0; arcache_o/awcache_o = 0; arprot_o/awprot_o = 0  (constant outputs)

Behaviour:
- Reset (reset_i=0, async): state=IDLE; all valid/ready outputs 0; ok pulses 0; rdata_o=0; discard=0; awdone=wdone=0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, HOLD.
- IDLE:
  - ren_i & ~cache_ena_i -> latch araddr = {addr_i[31:2], 2'b00}, arsize = RD_SIZE; go to RD_ADDR.
  - Otherwise |wen_i & ~cache_ena_i -> latch addr, strobes and data; go to WR_REQ.
  - Read has priority over write if both are asserted.
- Write size/address from wen_i:
  - 1111 -> size 2, addr[1:0]=00.
  - 0011 / 1100 -> size 1, addr[1:0]=00 / 10.
  - Single bit k -> size 0, addr[1:0]=k.
  - Any other pattern -> size 2, word-aligned.
  - wstrb_o = wen_i unmodified; wlast_o = 1.
- RD_ADDR: arvalid_o=1 until arready_i, then RD_DATA.
- RD_DATA: rready_o=1. On rvalid_i & rid_i==AXI_ID:
  - register rdata_o <= rdata_i;
  - read_ok_o=1 in the next cycle unless discard is set;
  - go to HOLD.
- WR_REQ: awvalid_o and wvalid_o asserted together, each dropped independently on its ready (awdone/wdone). When both are done, go to WR_RESP; the same-cycle double handshake is allowed.
- WR_RESP: bready_o=1. On bvalid_i & bid_i==AXI_ID -> write_ok_o=1 the next cycle unless discard; go to HOLD.
- HOLD: exactly one cycle; the ok pulse is emitted here; new requests are ignored (upstream still holds wen for this cycle); then IDLE.
- Latency, zero-wait slave: read request to read_ok = 3 cycles; write request to write_ok = 3 cycles.
- Flush:
  - flush_i in any non-IDLE state sets discard; the AXI transaction still completes.
  - No ok pulse is produced for a discarded request; discard clears on entering IDLE.
  - flush_i in IDLE with a request the same cycle -> the request is not accepted.
- rresp/bresp errors are ignored; the ok pulse is still produced.
- Mismatched rid/bid responses are accepted (ready held) and dropped; the state does not advance.
- Valid signals never drop before their handshake (AXI rule).
- Requests arriving while busy_o=1 are not queued; upstream holds or re-issues them.

Test Plan:
- Uncached lw: ren=1 at addr 0xBFAF_8004 (upstream-translated 0x1FAF_8004), arready/rvalid immediate, rdata_i=0xDEADBEEF -> araddr_o=0x1FAF_8004, arsize_o=2; read_ok_o pulses at cycle 3 with rdata_o=0xDEADBEEF.
- sb strobe 0100 at 0x1FAF_F020, wdata 0x00AA0000 -> awaddr_o=0x1FAF_F022, awsize_o=0, wstrb_o=0100; write_ok_o pulses once after bvalid; wen still high in the HOLD cycle does not start a second write.
- AW/W skew: awready at cycle 1, wready at cycle 4 -> awvalid_o drops after cycle 1, wvalid_o held until cycle 4; bready_o asserted only afterwards; exactly one write_ok_o.
- Flush during RD_DATA with rvalid delayed 5 cycles -> rready_o stays 1 and the R beat is consumed; read_ok_o never pulses; busy_o falls afterwards; the next read is serviced normally.
- cache_ena_i=1 with ren=1 -> no AXI activity, busy_o=0. Simultaneous ren and wen=1111 -> read is issued first.
- reset_i low during WR_RESP -> all outputs return to reset values immediately (async), state=IDLE.
